// File: rtl/butterfly_feeder_pkg.sv
// Shared FFT types and helpers for the radix-2 DIF input commutator.
package butterfly_feeder_pkg;

    localparam int unsigned FFT_DATA_W = 16;

    typedef logic [FFT_DATA_W-1:0] FFT_DATA_SAMPLE;

    typedef struct packed {
        FFT_DATA_SAMPLE data;
        logic           valid;
    } FFT_DATA_BUS;

    // Frame phase is the counter MSB: first half buffers, second half pairs.
    typedef enum logic {
        PH_FILL = 1'b0,
        PH_PAIR = 1'b1
    } phase_e;

    function automatic int unsigned FFT_HALF(input int unsigned set);
        return 32'(1) << (set - 32'(1));
    endfunction

    // Address width for a buffer of the given depth; a single entry still gets one bit.
    function automatic int unsigned buf_addr_w(input int unsigned depth);
        return (depth > 32'(1)) ? $clog2(depth) : 32'(1);
    endfunction

endpackage

// File: rtl/butterfly_feeder_if.sv
// Sample input and butterfly-pair output bundle of the commutator.
interface butterfly_feeder_if;
    import butterfly_feeder_pkg::*;

    FFT_DATA_BUS in;
    logic        in_sop;
    FFT_DATA_BUS up;
    FFT_DATA_BUS down;
    logic        sync_err;
    logic        fill;

    modport master (
        output in,
        output in_sop,
        input  up,
        input  down,
        input  sync_err,
        input  fill
    );

    modport slave (
        input  in,
        input  in_sop,
        output up,
        output down,
        output sync_err,
        output fill
    );

endinterface

// File: rtl/butterfly_feeder_buf.sv
// First-half sample store: one synchronous write port, one combinational read port.
module feeder_buf
    import butterfly_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [buf_addr_w(DEPTH)-1:0] waddr_i,
    input  FFT_DATA_SAMPLE               wdata_i,
    input  logic [buf_addr_w(DEPTH)-1:0] raddr_i,
    output FFT_DATA_SAMPLE               rdata_o
);

    if (DEPTH == 1) begin : g_single
        FFT_DATA_SAMPLE mem_q;
        logic           unused_addr;

        // With one entry the addresses carry no information.
        assign unused_addr = ^{waddr_i, raddr_i};

        always_ff @(posedge clk) begin
            if (we_i) begin
                mem_q <= wdata_i;
            end
        end

        assign rdata_o = mem_q;
    end else begin : g_array
        FFT_DATA_SAMPLE mem_q [DEPTH];

        always_ff @(posedge clk) begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
        end

        assign rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/butterfly_feeder.sv
// Radix-2 DIF input commutator: buffers the first half of each frame, then
// emits (x[k], x[k+N/2]) pairs alongside the second-half samples.
module butterfly_feeder
    import butterfly_feeder_pkg::*;
#(
    parameter int unsigned SET = 4
) (
    input  logic               clk,
    input  logic               rst,
    butterfly_feeder_if.slave  bus
);

    localparam int unsigned HALF = FFT_HALF(SET);
    localparam int unsigned AW   = buf_addr_w(HALF);

    logic [SET-1:0] cnt_q, cnt_d;
    FFT_DATA_BUS    up_q, up_d;
    FFT_DATA_BUS    down_q, down_d;
    logic           sync_err_q, sync_err_d;

    logic [AW-1:0]  addr_c;
    logic [AW-1:0]  wr_addr_c;
    logic           wr_en_c;
    FFT_DATA_SAMPLE rd_data_c;
    phase_e         phase_c;

    // Buffer index is the counter without its phase bit.
    if (SET > 1) begin : g_addr
        assign addr_c = cnt_q[AW-1:0];
    end else begin : g_addr_single
        assign addr_c = '0;
    end

    assign phase_c = phase_e'(cnt_q[SET-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            up_q       <= '0;
            down_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            up_q       <= up_d;
            down_q     <= down_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Outputs default to all-zero so idle cycles present quiet data to the butterfly.
    always_comb begin
        cnt_d      = cnt_q;
        up_d       = '0;
        down_d     = '0;
        sync_err_d = 1'b0;
        wr_en_c    = 1'b0;
        wr_addr_c  = addr_c;

        if (bus.in.valid) begin
            if (bus.in_sop && (cnt_q != '0)) begin
                // Early start-of-frame: restart with this sample as x[0].
                sync_err_d = 1'b1;
                wr_en_c    = 1'b1;
                wr_addr_c  = '0;
                cnt_d      = SET'(1);
            end else if (phase_c == PH_FILL) begin
                wr_en_c = 1'b1;
                cnt_d   = cnt_q + SET'(1);
            end else begin
                up_d.data    = rd_data_c;
                up_d.valid   = 1'b1;
                down_d.data  = bus.in.data;
                down_d.valid = 1'b1;
                cnt_d        = cnt_q + SET'(1);
            end
        end
    end

    feeder_buf #(
        .DEPTH (HALF)
    ) u_buf (
        .clk     (clk),
        .we_i    (wr_en_c),
        .waddr_i (wr_addr_c),
        .wdata_i (bus.in.data),
        .raddr_i (addr_c),
        .rdata_o (rd_data_c)
    );

    assign bus.up       = up_q;
    assign bus.down     = down_q;
    assign bus.sync_err = sync_err_q;
    assign bus.fill     = ~cnt_q[SET-1];

endmodule

// File: tb/tb_butterfly_feeder.sv
// Directed bench for butterfly_feeder at SET=3 and SET=1 with a pair scoreboard.
module tb_butterfly_feeder;
    import butterfly_feeder_pkg::*;

    typedef struct {
        logic [15:0] u;
        logic [15:0] d;
    } pair_t;

    logic clk = 1'b0;
    logic rst3;
    logic rst1;

    int n_assert = 0;
    int n_fail   = 0;

    pair_t q3[$];
    pair_t q1[$];

    butterfly_feeder_if bf3 ();
    butterfly_feeder_if bf1 ();

    butterfly_feeder #(.SET(3)) u3 (
        .clk (clk),
        .rst (rst3),
        .bus (bf3.slave)
    );

    butterfly_feeder #(.SET(1)) u1 (
        .clk (clk),
        .rst (rst1),
        .bus (bf1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bf3.in.valid = 1'b0;
        bf3.in.data  = 16'hDEAD;
        bf3.in_sop   = 1'b0;
        bf1.in.valid = 1'b0;
        bf1.in.data  = 16'hDEAD;
        bf1.in_sop   = 1'b0;
    endtask

    // Outputs of one DUT after an edge: expected quiet bus.
    task automatic chk_quiet(input int d, input string tag, input logic exp_fill);
        FFT_DATA_BUS up, dn;
        logic        err, fl;
        up  = (d == 3) ? bf3.up       : bf1.up;
        dn  = (d == 3) ? bf3.down     : bf1.down;
        err = (d == 3) ? bf3.sync_err : bf1.sync_err;
        fl  = (d == 3) ? bf3.fill     : bf1.fill;
        chk({tag, "_up"},   32'(up),  32'd0);
        chk({tag, "_down"}, 32'(dn),  32'd0);
        chk({tag, "_err"},  32'(err), 32'd0);
        chk({tag, "_fill"}, 32'(fl),  32'(exp_fill));
    endtask

    // One clock of stimulus on DUT d; expected pair pushed on drive, popped on output.
    task automatic step(input int d, input bit v, input bit sop, input int x,
                        input int exp_fill, input bit exp_pair,
                        input int eu, input int ed, input bit exp_err);
        FFT_DATA_BUS up, dn;
        logic        err, fl;
        pair_t       p;
        if (d == 3) begin
            bf3.in.valid = v;
            bf3.in.data  = 16'(x);
            bf3.in_sop   = sop;
            fl           = bf3.fill;
        end else begin
            bf1.in.valid = v;
            bf1.in.data  = 16'(x);
            bf1.in_sop   = sop;
            fl           = bf1.fill;
        end
        if (exp_fill >= 0) chk("fill", 32'(fl), 32'(exp_fill));
        if (exp_pair) begin
            p.u = 16'(eu);
            p.d = 16'(ed);
            if (d == 3) q3.push_back(p);
            else        q1.push_back(p);
        end
        @(posedge clk);
        #1;
        up  = (d == 3) ? bf3.up       : bf1.up;
        dn  = (d == 3) ? bf3.down     : bf1.down;
        err = (d == 3) ? bf3.sync_err : bf1.sync_err;
        idle_inputs();
        chk("sync_err",   32'(err),      32'(exp_err));
        chk("up_valid",   32'(up.valid), 32'(exp_pair));
        chk("down_valid", 32'(dn.valid), 32'(exp_pair));
        if (up.valid) begin
            if ((d == 3 && q3.size() == 0) || (d == 1 && q1.size() == 0)) begin
                chk("sb_unexpected_pair", 32'd1, 32'd0);
            end else begin
                p = (d == 3) ? q3.pop_front() : q1.pop_front();
                chk("up_data",   32'(up.data), 32'(p.u));
                chk("down_data", 32'(dn.data), 32'(p.d));
            end
        end else begin
            chk("up_data_gated",   32'(up.data), 32'd0);
            chk("down_data_gated", 32'(dn.data), 32'd0);
        end
    endtask

    initial begin
        idle_inputs();
        rst3 = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet(3, "reset3", 1'b1);
        chk_quiet(1, "reset1", 1'b1);
        rst3 = 1'b0;
        rst1 = 1'b0;

        // Single frame 1..8 with sop on the first sample.
        for (int i = 1; i <= 8; i++)
            step(3, 1'b1, i == 1, i, (i <= 4) ? 1 : 0, i >= 5, i - 4, i, 1'b0);

        // Two back-to-back frames 1..16.
        for (int i = 1; i <= 16; i++) begin
            int j;
            j = (i - 1) % 8 + 1;
            step(3, 1'b1, j == 1, i, (j <= 4) ? 1 : 0, j >= 5, i - 4, i, 1'b0);
        end

        // Gapped frame; sop during gaps must be ignored.
        for (int i = 1; i <= 8; i++) begin
            step(3, 1'b1, i == 1, i, (i <= 4) ? 1 : 0, i >= 5, i - 4, i, 1'b0);
            step(3, 1'b0, 1'b1, 16'hBEEF, (i < 4 || i == 8) ? 1 : 0, 1'b0, 0, 0, 1'b0);
        end

        // Early sop after three samples aborts the frame.
        for (int i = 1; i <= 3; i++)
            step(3, 1'b1, i == 1, i, 1, 1'b0, 0, 0, 1'b0);
        step(3, 1'b1, 1'b1, 20, 1, 1'b0, 0, 0, 1'b1);
        for (int k = 1; k <= 7; k++)
            step(3, 1'b1, 1'b0, 20 + k, (k < 4) ? 1 : 0, k >= 4, 20 + k - 4, 20 + k, 1'b0);

        // Reset during PAIR, with a would-be abort sample on the reset cycle.
        for (int i = 1; i <= 6; i++)
            step(3, 1'b1, i == 1, i, (i <= 4) ? 1 : 0, i >= 5, i - 4, i, 1'b0);
        rst3         = 1'b1;
        bf3.in.valid = 1'b1;
        bf3.in.data  = 16'd7;
        bf3.in_sop   = 1'b1;
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        idle_inputs();
        chk_quiet(3, "midreset", 1'b1);
        for (int i = 1; i <= 8; i++)
            step(3, 1'b1, i == 1, 30 + i, (i <= 4) ? 1 : 0, i >= 5, 30 + i - 4, 30 + i, 1'b0);

        // SET=1: single-register buffer, pairs of adjacent samples.
        step(1, 1'b1, 1'b1, 1, 1, 1'b0, 0, 0, 1'b0);
        step(1, 1'b1, 1'b0, 2, 0, 1'b1, 1, 2, 1'b0);
        step(1, 1'b1, 1'b0, 3, 1, 1'b0, 0, 0, 1'b0);
        step(1, 1'b1, 1'b0, 4, 0, 1'b1, 3, 4, 1'b0);
        step(1, 1'b0, 1'b0, 0, 1, 1'b0, 0, 0, 1'b0);

        chk("sb3_drained", 32'(q3.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
